// File: rtl/fresh_fill_ctrl.sv
// fresh_fill_ctrl: drains freshness ranges from the range FIFO into the
// one-bit-per-address freshness bitmap RAM, then signals check_ready so the
// lookup path can take over the RAM read port.
//
// Build option: define FRESH_FILL_CLEAR_EN to include the reset-time sweep
// that zeroes the whole bitmap before any range is applied. Without it, the
// RAM has to come up zeroed by other means and pops may start right away.
//
// state | meaning
// CLEAR | zeroing sweep, one address per cycle (FRESH_FILL_CLEAR_EN only)
// IDLE  | waiting for a range; pops when the FIFO is non-empty
// POP   | FIFO read latency cycle (standard-mode FIFO)
// LATCH | capture low/high/fresh, reject low > high
// FILL  | write fresh bit from low up to high, one address per cycle

module fresh_fill_ctrl #(
   parameter int ADDR_W = 17,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [ADDR_W-1:0] fifo_range_low,
   input  logic [ADDR_W-1:0] fifo_range_high,
   input  logic              fifo_range_fresh,
   input  logic              ranges_done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_din,
   output logic              check_ready,
   output logic              busy,
   output logic              range_err,
   output logic [CNT_W-1:0]  ranges_applied
);

   typedef enum logic [2:0] {
`ifdef FRESH_FILL_CLEAR_EN
      CLEAR,
`endif
      IDLE,
      POP,
      LATCH,
      FILL
   } state_t;

`ifdef FRESH_FILL_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = IDLE;
`endif

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   cur_addr;
   logic [ADDR_W-1:0]   cur_addr_nxt;
   logic [ADDR_W-1:0]   high_q;
   logic [ADDR_W-1:0]   high_nxt;
   logic                fresh_q;
   logic                fresh_nxt;

   logic                rd_en_nxt;
   logic                we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic                din_nxt;
   logic                ready_nxt;
   logic                err_nxt;
   logic [CNT_W-1:0]    applied_nxt;

   // Busy is a pure decode of the state register so it follows reset at once.
   assign busy = (state != IDLE);

   // State, range context and registered outputs; reset aborts any sweep or fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= RESET_STATE;
         cur_addr       <= '0;
         high_q         <= '0;
         fresh_q        <= 1'b0;
         fifo_rd_en     <= 1'b0;
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_din        <= 1'b0;
         check_ready    <= 1'b0;
         range_err      <= 1'b0;
         ranges_applied <= '0;
      end else begin
         state          <= state_nxt;
         cur_addr       <= cur_addr_nxt;
         high_q         <= high_nxt;
         fresh_q        <= fresh_nxt;
         fifo_rd_en     <= rd_en_nxt;
         ram_we         <= we_nxt;
         ram_addr       <= addr_nxt;
         ram_din        <= din_nxt;
         check_ready    <= ready_nxt;
         range_err      <= err_nxt;
         ranges_applied <= applied_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt    = state;
      cur_addr_nxt = cur_addr;
      high_nxt     = high_q;
      fresh_nxt    = fresh_q;
      rd_en_nxt    = 1'b0;
      we_nxt       = 1'b0;
      addr_nxt     = ram_addr;
      din_nxt      = ram_din;
      err_nxt      = range_err;
      applied_nxt  = ranges_applied;
      // Only IDLE with nothing queued and the producer finished counts as complete;
      // a newly pushed range drops this on the following edge.
      ready_nxt    = (state == IDLE) && fifo_empty && ranges_done;

      case (state)
`ifdef FRESH_FILL_CLEAR_EN
         CLEAR: begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            din_nxt  = 1'b0;
            if (cur_addr == ADDR_LAST) begin
               cur_addr_nxt = '0;
               state_nxt    = IDLE;
            end else begin
               cur_addr_nxt = cur_addr + 1'b1;
            end
         end
`endif
         IDLE: begin
            if (!fifo_empty) begin
               rd_en_nxt = 1'b1;
               state_nxt = POP;
            end
         end
         POP: begin
            state_nxt = LATCH;
         end
         LATCH: begin
            high_nxt  = fifo_range_high;
            fresh_nxt = fifo_range_fresh;
            if (fifo_range_low > fifo_range_high) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cur_addr_nxt = fifo_range_low;
               state_nxt    = FILL;
            end
         end
         FILL: begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            din_nxt  = fresh_q;
            // Equality test before the increment keeps a range ending at the
            // top address from wrapping back to zero.
            if (cur_addr == high_q) begin
               state_nxt = IDLE;
               if (ranges_applied != CNT_MAX) begin
                  applied_nxt = ranges_applied + 1'b1;
               end
            end else begin
               cur_addr_nxt = cur_addr + 1'b1;
            end
         end
         default: begin
            state_nxt = RESET_STATE;
         end
      endcase
   end

endmodule

// File: tb/tb_fresh_fill_ctrl.sv
// Directed bench for fresh_fill_ctrl at ADDR_W=5 with a standard-mode FIFO
// model and a behavioural bitmap RAM. Sweep checks apply when
// FRESH_FILL_CLEAR_EN is defined.

module tb_fresh_fill_ctrl;

   localparam int AW = 5;
   localparam int CW = 16;

`ifdef FRESH_FILL_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;
   localparam logic BM_INIT  = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
   localparam logic BM_INIT  = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [AW-1:0] fifo_range_low = '0;
   logic [AW-1:0] fifo_range_high = '0;
   logic          fifo_range_fresh = 1'b0;
   logic          ranges_done = 1'b0;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic          ram_din;
   logic          check_ready;
   logic          busy;
   logic          range_err;
   logic [CW-1:0] ranges_applied;

   fresh_fill_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .fifo_empty       (fifo_empty),
      .fifo_rd_en       (fifo_rd_en),
      .fifo_range_low   (fifo_range_low),
      .fifo_range_high  (fifo_range_high),
      .fifo_range_fresh (fifo_range_fresh),
      .ranges_done      (ranges_done),
      .ram_we           (ram_we),
      .ram_addr         (ram_addr),
      .ram_din          (ram_din),
      .check_ready      (check_ready),
      .busy             (busy),
      .range_err        (range_err),
      .ranges_applied   (ranges_applied)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Standard-mode FIFO: data appears the cycle after the pop strobe.
   logic [AW-1:0] q_lo [64];
   logic [AW-1:0] q_hi [64];
   logic          q_fr [64];
   int            wr_ptr = 0;
   int            rd_ptr = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
         fifo_range_low   <= q_lo[rd_ptr % 64];
         fifo_range_high  <= q_hi[rd_ptr % 64];
         fifo_range_fresh <= q_fr[rd_ptr % 64];
         rd_ptr           <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input logic fr);
      q_lo[wr_ptr % 64] = lo;
      q_hi[wr_ptr % 64] = hi;
      q_fr[wr_ptr % 64] = fr;
      wr_ptr++;
   endtask

   // Bitmap RAM model plus write statistics.
   logic bm   [32];
   int   hits [32];
   int   we_cnt = 0;

   initial begin
      for (int i = 0; i < 32; i++) begin
         bm[i]   = BM_INIT;
         hits[i] = 0;
      end
      forever begin
         @(posedge clk);
         if (ram_we === 1'b1) begin
            bm[ram_addr] = ram_din;
            hits[ram_addr]++;
            we_cnt++;
         end
      end
   end

   task automatic wait_ready(input string tag, input int budget);
      int n;
      n = 0;
      while (check_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(check_ready), 32'd1);
   endtask

   task automatic check_sweep(input string tag);
      int n;
      int bad;
      n = 0;
      while (ram_we !== 1'b1 && n < 4) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_first_addr"}, 32'(ram_addr), 32'd0);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (!(ram_we === 1'b1 && ram_addr === AW'(i) && ram_din === 1'b0)) bad++;
         @(negedge clk);
      end
      check({tag, "_seq_bad"}, 32'(bad), 32'd0);
      check({tag, "_we_after"}, 32'(ram_we), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   function automatic int popcount_bm();
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) if (bm[i] === 1'b1) c++;
      return c;
   endfunction

   int we0;
   int h0 [32];
   int n;
   int cnt;

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      check("rst_din", 32'(ram_din), 32'd0);
      check("rst_ready", 32'(check_ready), 32'd0);
      check("rst_err", 32'(range_err), 32'd0);
      check("rst_applied", 32'(ranges_applied), 32'd0);
      check("rst_busy", 32'(busy), 32'(BUSY_RST));
      rst = 1'b0;

      // Scenario 1: clear sweep then ready
`ifdef FRESH_FILL_CLEAR_EN
      check_sweep("clear");
      check("clear_we_cnt", we_cnt, 32);
      check("clear_bitmap_ones", popcount_bm(), 0);
`else
      repeat (3) @(negedge clk);
      check("noclr_busy", 32'(busy), 32'd0);
      check("noclr_we_cnt", we_cnt, 0);
`endif
      ranges_done = 1'b1;
      wait_ready("s1", 5);
      ranges_done = 1'b0;
      repeat (2) @(negedge clk);
      check("s1_ready_drop", 32'(check_ready), 32'd0);

      // Scenario 2: four overlapping fresh ranges
      we0 = we_cnt;
      push(5'd3, 5'd5, 1'b1);
      push(5'd10, 5'd14, 1'b1);
      push(5'd16, 5'd20, 1'b1);
      push(5'd12, 5'd18, 1'b1);
      ranges_done = 1'b1;
      @(negedge clk);
      wait_ready("s2", 200);
      check("s2_writes", we_cnt - we0, 20);
      check("s2_applied", 32'(ranges_applied), 32'd4);
      check("s2_bm5", 32'(bm[5]), 32'd1);
      check("s2_bm11", 32'(bm[11]), 32'd1);
      check("s2_bm17", 32'(bm[17]), 32'd1);
      check("s2_bm1", 32'(bm[1]), 32'd0);
      check("s2_bm8", 32'(bm[8]), 32'd0);
      check("s2_bm0", 32'(bm[0]), 32'd0);
      cnt = int'(bm[5]) + int'(bm[11]) + int'(bm[17]) + int'(bm[1]) + int'(bm[8]) + int'(bm[0]);
      check("s2_fresh_count", cnt, 3);
      check("s2_popcount", popcount_bm(), 14);
      check("s2_err", 32'(range_err), 32'd0);

      // Scenario 3: range at top of address space must not wrap
      we0 = we_cnt;
      h0  = hits;
      push(5'd28, 5'd31, 1'b1);
      @(negedge clk);
      check("s3_ready_fall", 32'(check_ready), 32'd0);
      wait_ready("s3", 50);
      check("s3_writes", we_cnt - we0, 4);
      cnt = 0;
      for (int i = 28; i < 32; i++) if (hits[i] - h0[i] == 1) cnt++;
      check("s3_top_hits", cnt, 4);
      check("s3_addr0_hits", hits[0] - h0[0], 0);
      check("s3_busy", 32'(busy), 32'd0);
      check("s3_applied", 32'(ranges_applied), 32'd5);

      // Scenario 4: inverted range rejected, following range still written
      we0 = we_cnt;
      push(5'd9, 5'd4, 1'b1);
      @(negedge clk);
      wait_ready("s4a", 50);
      check("s4_inv_writes", we_cnt - we0, 0);
      check("s4_err_set", 32'(range_err), 32'd1);
      check("s4_inv_applied", 32'(ranges_applied), 32'd5);
      we0 = we_cnt;
      h0  = hits;
      push(5'd2, 5'd2, 1'b1);
      @(negedge clk);
      wait_ready("s4b", 50);
      check("s4_single_writes", we_cnt - we0, 1);
      check("s4_hit2", hits[2] - h0[2], 1);
      check("s4_bm2", 32'(bm[2]), 32'd1);
      check("s4_err_sticky", 32'(range_err), 32'd1);
      check("s4_applied", 32'(ranges_applied), 32'd6);

      // Scenario 5: late stale ranges reopen processing
      check("s5_ready_before", 32'(check_ready), 32'd1);
      we0 = we_cnt;
      h0  = hits;
      push(5'd7, 5'd7, 1'b0);
      @(negedge clk);
      check("s5_ready_fall", 32'(check_ready), 32'd0);
      wait_ready("s5a", 50);
      check("s5_writes", we_cnt - we0, 1);
      check("s5_hit7", hits[7] - h0[7], 1);
      check("s5_bm7", 32'(bm[7]), 32'd0);
      push(5'd11, 5'd11, 1'b0);
      @(negedge clk);
      wait_ready("s5b", 50);
      check("s5_bm11_cleared", 32'(bm[11]), 32'd0);
      check("s5_applied", 32'(ranges_applied), 32'd8);

      // Scenario 6: reset in the middle of a fill
      push(5'd0, 5'd31, 1'b1);
      n = 0;
      while (!(ram_we === 1'b1 && ram_addr === 5'd15) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("s6_reach_15", 32'(ram_addr), 32'd15);
      rst = 1'b1;
      #1;
      check("s6_rst_we", 32'(ram_we), 32'd0);
      check("s6_rst_applied", 32'(ranges_applied), 32'd0);
      check("s6_rst_addr", 32'(ram_addr), 32'd0);
      check("s6_rst_err", 32'(range_err), 32'd0);
      check("s6_rst_ready", 32'(check_ready), 32'd0);
      check("s6_rst_busy", 32'(busy), 32'(BUSY_RST));
      @(negedge clk);
      rst = 1'b0;
`ifdef FRESH_FILL_CLEAR_EN
      check_sweep("s6_clear");
`else
      repeat (2) @(negedge clk);
      check("s6_idle_we", 32'(ram_we), 32'd0);
      check("s6_idle_busy", 32'(busy), 32'd0);
`endif
      wait_ready("s6", 60);
      check("s6_applied_after", 32'(ranges_applied), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fresh_fill_ctrl.md
# fresh_fill_ctrl

Single-clock sequencer that turns queued freshness ranges into writes to the freshness bitmap RAM. After reset it optionally sweeps the RAM to zero. It then pops each range from the range FIFO's read side and writes the range's fresh bit to every address from low to high, one address per cycle. It raises `check_ready` once all ranges are applied, which hands the RAM read port over to the fast lookup path.

## Interface

Parameters:
- `ADDR_W`, 17, bitmap address width; the RAM depth is 2^ADDR_W one-bit words.
- `CNT_W`, 16, width of the applied-range counter.

Ports:
- `clk` input 1: processing clock; the FIFO read side and the RAM write port are on this clock.
- `rst` input 1: reset, asynchronous and active-high.
- `fifo_empty` input 1: range FIFO empty flag.
- `fifo_rd_en` output 1: FIFO pop strobe, one cycle per pop.
- `fifo_range_low` input ADDR_W: first address of the range, inclusive.
- `fifo_range_high` input ADDR_W: last address of the range, inclusive.
- `fifo_range_fresh` input 1: value written across the range.
- `ranges_done` input 1: level signal; the producer will write no more ranges.
- `ram_we` output 1: bitmap write enable.
- `ram_addr` output ADDR_W: bitmap write address.
- `ram_din` output 1: bitmap write data.
- `check_ready` output 1: bitmap is complete and safe to read.
- `busy` output 1: the block is clearing, popping or filling.
- `range_err` output 1: sticky flag; at least one range had low > high.
- `ranges_applied` output CNT_W: count of ranges fully written.

## Operation

- The state machine has five states: CLEAR, IDLE, POP, LATCH, FILL.
- Reset values:
  - `fifo_rd_en`, `ram_we`, `ram_addr`, `ram_din`, `check_ready`, `range_err` and `ranges_applied` all reset to 0.
  - `busy` resets to 1 if the clear sweep is compiled in, otherwise to 0.
  - The state resets to CLEAR if the clear sweep is compiled in, otherwise to IDLE.
- CLEAR:
  - Writes `ram_din`=0 to addresses 0 through 2^ADDR_W-1 in order, one per cycle.
  - Moves to IDLE after the write to the last address.
- IDLE:
  - If `fifo_empty`=0, assert `fifo_rd_en` for one cycle and go to POP.
  - Otherwise stay in IDLE.
- POP: a wait cycle for the standard-mode FIFO, whose read data is valid one cycle after `fifo_rd_en`. Go to LATCH.
- LATCH: capture low, high and fresh from the FIFO outputs.
  - If low > high, set `range_err`, do not write, and return to IDLE; `ranges_applied` is unchanged.
  - Otherwise set the current address to low and go to FILL.
- FILL:
  - Each cycle drive `ram_we`=1, `ram_addr`=current address and `ram_din`=the latched fresh value.
  - When the current address equals high, increment `ranges_applied` and return to IDLE.
  - The end test compares for equality before incrementing. A range ending at 2^ADDR_W-1 must terminate and never wrap to 0.
- Overlapping ranges are applied in FIFO order, so the last write to an address wins.
- `ranges_applied` saturates at 2^CNT_W-1.
- `check_ready` is registered. It is 1 in any cycle where the state is IDLE, `fifo_empty`=1 and `ranges_done`=1.
- If a new range arrives after `check_ready` has risen, `check_ready` falls in the cycle after `fifo_empty` deasserts, and processing resumes.
- `busy` is 1 whenever the state is not IDLE.
- Reset asserted mid-fill or mid-clear aborts immediately. All outputs return to their reset values on the same edge, and any partially written range is lost.

## Timing

- Pop-to-first-write latency: `fifo_rd_en` is high in cycle N; the first `ram_we` is in cycle N+3.
- A range of length L occupies 2 + L cycles from the pop to the last write. IDLE adds 1 more cycle before the next pop.
- Clear sweep: exactly 2^ADDR_W cycles with `ram_we`=1. The first clear write is in the first cycle after reset deasserts.
- `ram_we`, `ram_addr` and `ram_din` are registered. The RAM samples them on the edge after they are driven.
- `check_ready` rises no earlier than 1 cycle after the final FILL write.

## Configuration

- Macro: `FRESH_FILL_CLEAR_EN`.
- Defined:
  - The CLEAR state and sweep are built in.
  - `busy` resets to 1 and `check_ready` cannot assert until the sweep finishes.
- Undefined:
  - The CLEAR state is removed and reset enters IDLE.
  - The RAM must be initialised to zero by configuration or initial contents.
  - FIFO pops may begin on the first cycle after reset.

## Test plan

All scenarios use ADDR_W=5 with a standard-mode FIFO model.

1. Reset with `FRESH_FILL_CLEAR_EN` defined -> 32 consecutive `ram_we` cycles, addresses 0..31, `ram_din`=0. Then `busy`=0; `check_ready`=1 once `ranges_done`=1 and the FIFO is empty.
2. Ranges 3-5, 10-14, 16-20, 12-18 with fresh=1, then `ranges_done`=1 ->
   - 20 `ram_we` cycles in total and `ranges_applied`=4.
   - Bitmap reads: 5, 11 and 17 return 1; 1, 8 and 32 mod 32 = 0 return 0, so the fresh count is 3.
3. Single range 28-31 -> writes to 28, 29, 30, 31 only; no write to address 0; state returns to IDLE.
4. Range 9-4 -> no `ram_we`, `range_err`=1 and stays set, `ranges_applied` unchanged. A following range 2-2 is still written once.
5. With `check_ready`=1, push range 7-7 with fresh=0 -> `check_ready` falls, one write to 7 with `ram_din`=0, then `check_ready` rises again.
6. Assert `rst` during the fill of range 0-31 at address 15 -> `ram_we`=0 and `ranges_applied`=0 on that edge. The clear sweep restarts from address 0 after deassertion.
